// File: rtl/rgb_fade_ctrl_if.sv
// Bus between the encoder target registers / PWM period counter and the
// fade sequencer, plus read-only debug taps of the sequencer state.
interface rgb_fade_ctrl_if #(
  parameter int WIDTH = 8
);
  // Handshake: there is no valid/ready pair. Targets are level-sampled and
  // period_end is a one-cycle strobe. The three levels are always valid;
  // load strobes for one cycle when they have just been committed together.
  logic             enable;
  logic             period_end;
  logic [WIDTH-1:0] target0;
  logic [WIDTH-1:0] target1;
  logic [WIDTH-1:0] target2;
  logic [WIDTH-1:0] level0;
  logic [WIDTH-1:0] level1;
  logic [WIDTH-1:0] level2;
  logic             load;
  logic             busy;
  // Sequencer state: 0 IDLE, 1 STEP0, 2 STEP1, 3 STEP2, 4 COMMIT.
  logic [2:0]       dbg_state;
  logic [15:0]      dbg_pcnt;

  modport master (
    output enable, period_end, target0, target1, target2,
    input  level0, level1, level2, load, busy, dbg_state, dbg_pcnt
  );

  modport slave (
    input  enable, period_end, target0, target1, target2,
    output level0, level1, level2, load, busy, dbg_state, dbg_pcnt
  );
endinterface

// File: rtl/rgb_fade_ctrl.sv
// Ramps three PWM duties toward their targets by at most STEP every DIV PWM
// periods, using one shared step unit and committing all three on a period wrap.
module rgb_fade_ctrl #(
  parameter int WIDTH = 8,
  parameter int STEP  = 4,
  parameter int DIV   = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  rgb_fade_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP0  = 3'd1,
    S_STEP1  = 3'd2,
    S_STEP2  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam logic [15:0]  DIV_M1 = 16'(DIV - 1);
  localparam logic [WIDTH:0] STEP_X = STEP[WIDTH:0];

  state_t           r_state;
  logic [15:0]      r_pcnt;
  logic             r_load;
  logic [WIDTH-1:0] r_level0, r_level1, r_level2;
  logic [WIDTH-1:0] r_nxt0, r_nxt1, r_nxt2;

  logic             w_tick;
  logic [WIDTH-1:0] w_sel_level;
  logic [WIDTH-1:0] w_sel_target;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_mag;
  logic [WIDTH:0]   w_amt;
  logic             w_up;
  logic             w_dn;
  logic [WIDTH-1:0] w_next;

  assign w_tick = bus.period_end & bus.enable & (r_pcnt == DIV_M1);

  // Shared step unit: the STEPn state selects which channel it serves.
  always_comb begin
    w_sel_level  = r_level0;
    w_sel_target = bus.target0;
    case (r_state)
      S_STEP1: begin
        w_sel_level  = r_level1;
        w_sel_target = bus.target1;
      end
      S_STEP2: begin
        w_sel_level  = r_level2;
        w_sel_target = bus.target2;
      end
      default: begin
        w_sel_level  = r_level0;
        w_sel_target = bus.target0;
      end
    endcase
  end

  // The amount is clamped to the distance, so the result cannot overshoot
  // the target nor wrap past either end of the range.
  always_comb begin
    w_diff = {1'b0, w_sel_target} - {1'b0, w_sel_level};
    w_dn   = w_diff[WIDTH];
    w_up   = ~w_diff[WIDTH] & (w_diff != '0);
    w_mag  = w_dn ? ({1'b0, w_sel_level} - {1'b0, w_sel_target}) : w_diff;
    w_amt  = (w_mag < STEP_X) ? w_mag : STEP_X;
    w_next = w_sel_level;
    if (w_up) begin
      w_next = w_sel_level + w_amt[WIDTH-1:0];
    end else if (w_dn) begin
      w_next = w_sel_level - w_amt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pcnt   <= '0;
      r_load   <= 1'b0;
      r_level0 <= '0;
      r_level1 <= '0;
      r_level2 <= '0;
      r_nxt0   <= '0;
      r_nxt1   <= '0;
      r_nxt2   <= '0;
    end else begin
      r_load <= 1'b0;
      if (!bus.enable) begin
        // Dropping enable abandons any half-built update; levels hold.
        r_state <= S_IDLE;
        r_pcnt  <= '0;
      end else begin
        if (bus.period_end) begin
          r_pcnt <= (r_pcnt == DIV_M1) ? 16'd0 : r_pcnt + 16'd1;
        end
        case (r_state)
          S_IDLE: begin
            if (w_tick) r_state <= S_STEP0;
          end
          S_STEP0: begin
            r_nxt0  <= w_next;
            r_state <= S_STEP1;
          end
          S_STEP1: begin
            r_nxt1  <= w_next;
            r_state <= S_STEP2;
          end
          S_STEP2: begin
            r_nxt2  <= w_next;
            r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            // Commit only on a wrap so no PWM sees a mid-period duty change.
            if (bus.period_end) begin
              r_level0 <= r_nxt0;
              r_level1 <= r_nxt1;
              r_level2 <= r_nxt2;
              r_load   <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.level0    = r_level0;
  assign bus.level1    = r_level1;
  assign bus.level2    = r_level2;
  assign bus.load      = r_load;
  assign bus.dbg_state = r_state;
  assign bus.dbg_pcnt  = r_pcnt;
  assign bus.busy      = (r_state != S_IDLE) |
                         (r_level0 != bus.target0) |
                         (r_level1 != bus.target1) |
                         (r_level2 != bus.target2);

endmodule
